// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Latency: none (declarations only).
// Backpressure: none.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int GATE_SEL_W   = 3;
  localparam int WIN_EXP_BASE = 8;
  localparam int WIN_CNT_W    = 16;

  // Terminal down-counter load for a gate window: 2^(gs+8) - 1, built with a shift.
  function automatic logic [WIN_CNT_W-1:0] window_last(input logic [GATE_SEL_W-1:0] gs);
    window_last = (WIN_CNT_W'(1) << (WIN_EXP_BASE + int'(gs))) - WIN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// Two-flop synchronizer for the async oscillator plus a rising-edge detector.
// Latency: rise asserts 2-3 clk after an osc edge, depending on phase.
// Backpressure: none; clr forgets the edge history so a new run starts clean.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  // Metastability chain and one-cycle history of the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      hist  <= clr ? 1'b0 : sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Counts ring-oscillator rising edges over a programmable clk gate window.
// Latency: start -> done = SETTLE_CYC + 2^(gate_sel+8) + 1 cycles.
// Backpressure: start is ignored while busy; ena low aborts without publishing.
module ring_osc_freq_meter
  import ring_osc_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic                  osc_in,
  output logic                  osc_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      count,
  output logic                  sat
);

  state_t                 state_q;
  state_t                 state_d;
  logic [GATE_SEL_W-1:0]  gate_q;
  logic [WIN_CNT_W-1:0]   win_cnt;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_nxt;
  logic                   sat_flag;
  logic                   sat_nxt;
  logic                   rise;
  logic                   win_zero;
  logic                   enter_settle;
  logic                   enter_measure;
  logic                   publish;

  assign win_zero = (win_cnt == '0);
  assign busy     = (state_q != ST_IDLE);

  osc_sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter_settle),
    .d     (osc_in),
    .rise  (rise)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and transition strobes; ena low in SETTLE/MEASURE aborts to IDLE.
  always_comb begin
    state_d       = state_q;
    enter_settle  = 1'b0;
    enter_measure = 1'b0;
    publish       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && ena) begin
          state_d      = ST_SETTLE;
          enter_settle = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!ena) begin
          state_d = ST_IDLE;
        end else if (win_zero) begin
          state_d       = ST_MEASURE;
          enter_measure = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!ena) begin
          state_d = ST_IDLE;
        end else if (win_zero) begin
          state_d = ST_DONE;
          publish = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating accumulator step; the last window cycle's edge is folded into the publish.
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat_flag;
    if (state_q == ST_MEASURE && rise) begin
      if (acc == {CNT_W{1'b1}}) sat_nxt = 1'b1;
      else                      acc_nxt = acc + CNT_W'(1);
    end
  end

  // Latch the gate select at the accepted start so later changes cannot stretch the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            gate_q <= '0;
    else if (enter_settle) gate_q <= gate_sel;
  end

  // One down-counter times both the settle period and the gate window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (enter_settle) begin
      win_cnt <= WIN_CNT_W'(SETTLE_CYC - 1);
    end else if (enter_measure) begin
      win_cnt <= window_last(gate_q);
    end else if ((state_q == ST_SETTLE || state_q == ST_MEASURE) && !win_zero) begin
      win_cnt <= win_cnt - WIN_CNT_W'(1);
    end
  end

  // Edge accumulator and overflow flag, cleared as the window opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (enter_measure) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else begin
      acc      <= acc_nxt;
      sat_flag <= sat_nxt;
    end
  end

  // Published result: updated only on a completed window, done high during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done  <= 1'b0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      done <= publish;
      if (publish) begin
        count <= acc_nxt;
        sat   <= sat_nxt;
      end
    end
  end

  // Oscillator enable follows the next state so it drops the cycle after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) osc_en <= 1'b0;
    else        osc_en <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
`timescale 1ns/1ps
module tb_ring_osc_freq_meter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [2:0]  gate_sel;
  logic        osc_in;
  logic        osc_en,  busy,  done,  sat;
  logic [15:0] count;
  logic        osc_en8, busy8, done8, sat8;
  logic [7:0]  count8;

  int n_checks = 0;
  int n_fail   = 0;
  int osc_half = 0;   // half period in ns, 0 = hold osc_hold
  logic osc_hold = 1'b0;

  ring_osc_freq_meter #(.CNT_W(16), .SETTLE_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .gate_sel(gate_sel),
    .osc_in(osc_in), .osc_en(osc_en), .busy(busy), .done(done), .count(count), .sat(sat)
  );

  ring_osc_freq_meter #(.CNT_W(8), .SETTLE_CYC(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .gate_sel(gate_sel),
    .osc_in(osc_in), .osc_en(osc_en8), .busy(busy8), .done(done8), .count(count8), .sat(sat8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator edges sit at 3 ns mod 10, well away from clk edges.
  initial begin
    osc_in = 1'b0;
    #3;
    forever begin
      if (osc_half == 0) begin
        osc_in = osc_hold;
        #10;
      end else begin
        #(osc_half) osc_in = ~osc_in;
      end
    end
  end

  // Pulse start for one cycle; returns at the negedge after the sampling edge (cycle 1).
  task automatic pulse_start(input logic [2:0] gs);
    @(negedge clk);
    gate_sel = gs;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    gate_sel = ~gs;
  endtask

  task automatic wait_done(input int cyc0, input int limit, output int cyc, output bit seen);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    seen = (done === 1'b1);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (osc_en !== 1'b0) begin n_fail++; $display("FAIL reset_osc_en: got %b required 0", osc_en); end
    n_checks++; if (busy   !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (done   !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (count  !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
    n_checks++; if (sat    !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b required 0", sat); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; bit seen;
    osc_half = 40;
    repeat (4) @(negedge clk);
    pulse_start(3'd0);
    n_checks++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
    n_checks++; if (osc_en !== 1'b1) begin n_fail++; $display("FAIL basic_osc_en: got %b required 1", osc_en); end
    wait_done(1, 1000, cyc, seen);
    n_checks++; if (!seen || cyc != 16 + 256 + 1) begin n_fail++; $display("FAIL basic_latency: got %0d (seen=%0d) required 273", cyc, seen); end
    n_checks++; if ($isunknown(count) || count < 16'd31 || count > 16'd33) begin n_fail++; $display("FAIL basic_count: got %0d required 31..33", count); end
    n_checks++; if (sat !== 1'b0)    begin n_fail++; $display("FAIL basic_sat: got %b required 0", sat); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL basic_done_width: got %b required 0", done); end
    n_checks++; if (busy !== 1'b0 || osc_en !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b osc_en=%b required 0 0", busy, osc_en); end
  endtask

  task automatic test_saturation();
    int cyc; bit seen;
    osc_half = 20;
    repeat (4) @(negedge clk);
    pulse_start(3'd2);
    wait_done(1, 2000, cyc, seen);
    n_checks++; if (!seen || cyc != 16 + 1024 + 1) begin n_fail++; $display("FAIL sat_latency: got %0d (seen=%0d) required 1041", cyc, seen); end
    n_checks++; if (count8 !== 8'd255) begin n_fail++; $display("FAIL sat_count8: got %0d required 255", count8); end
    n_checks++; if (sat8 !== 1'b1)     begin n_fail++; $display("FAIL sat_flag8: got %b required 1", sat8); end
    n_checks++; if ($isunknown(count) || count < 16'd255 || count > 16'd257) begin n_fail++; $display("FAIL sat_count16: got %0d required 255..257", count); end
    n_checks++; if (sat !== 1'b0)      begin n_fail++; $display("FAIL sat_flag16: got %b required 0", sat); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    osc_half = 40;
    pulse_start(3'd1);
    repeat (16 + 100) @(negedge clk);
    n_checks++; if (osc_en !== 1'b1) begin n_fail++; $display("FAIL abort_pre_osc_en: got %b required 1", osc_en); end
    ena = 1'b0;
    @(negedge clk);
    n_checks++; if (osc_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_stop: got osc_en=%b busy=%b required 0 0", osc_en, busy); end
    repeat (600) begin
      @(negedge clk);
      if (done === 1'b1 || done8 === 1'b1) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got done pulse required none"); end
    n_checks++; if (count8 !== 8'd255 || sat8 !== 1'b1) begin n_fail++; $display("FAIL abort_hold8: got %0d/%b required 255/1", count8, sat8); end
    n_checks++; if ($isunknown(count) || count < 16'd255 || count > 16'd257 || sat !== 1'b0) begin n_fail++; $display("FAIL abort_hold16: got %0d/%b required 255..257/0", count, sat); end
    ena = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignore_restart();
    int cyc; bit seen;
    osc_half = 40;
    pulse_start(3'd0);
    repeat (16 + 50) @(negedge clk);
    gate_sel = 3'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(68, 3000, cyc, seen);
    n_checks++; if (!seen || cyc != 16 + 256 + 1) begin n_fail++; $display("FAIL restart_latency: got %0d (seen=%0d) required 273", cyc, seen); end
    n_checks++; if ($isunknown(count) || count < 16'd31 || count > 16'd33) begin n_fail++; $display("FAIL restart_count: got %0d required 31..33", count); end
    n_checks++; if (count8 < 8'd31 || count8 > 8'd33 || sat8 !== 1'b0) begin n_fail++; $display("FAIL restart_count8: got %0d/%b required 31..33/0", count8, sat8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_settle();
    int cyc; bit seen;
    osc_half = 40;
    pulse_start(3'd0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (osc_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got osc_en=%b busy=%b done=%b required 0 0 0", osc_en, busy, done); end
    n_checks++; if (count !== 16'd0 || sat !== 1'b0) begin n_fail++; $display("FAIL rst_mid_result: got %0d/%b required 0/0", count, sat); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || osc_en !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume: got busy=%b osc_en=%b required 0 0", busy, osc_en); end
    pulse_start(3'd0);
    wait_done(1, 1000, cyc, seen);
    n_checks++; if (!seen || cyc != 16 + 256 + 1) begin n_fail++; $display("FAIL rst_after_latency: got %0d (seen=%0d) required 273", cyc, seen); end
    n_checks++; if ($isunknown(count) || count < 16'd31 || count > 16'd33 || sat !== 1'b0) begin n_fail++; $display("FAIL rst_after_count: got %0d/%b required 31..33/0", count, sat); end
    @(negedge clk);
  endtask

  task automatic test_const_osc();
    int cyc; bit seen;
    osc_hold = 1'b1;
    osc_half = 0;
    repeat (4) @(negedge clk);
    pulse_start(3'd7);
    wait_done(1, 40000, cyc, seen);
    n_checks++; if (!seen || cyc != 16 + 32768 + 1) begin n_fail++; $display("FAIL const_latency: got %0d (seen=%0d) required 32785", cyc, seen); end
    n_checks++; if (count !== 16'd0 || sat !== 1'b0) begin n_fail++; $display("FAIL const_count: got %0d/%b required 0/0", count, sat); end
    n_checks++; if (count8 !== 8'd0 || sat8 !== 1'b0) begin n_fail++; $display("FAIL const_count8: got %0d/%b required 0/0", count8, sat8); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL const_done_width: got %b required 0", done); end
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    start    = 1'b0;
    gate_sel = 3'd0;
    test_reset();
    test_basic();
    test_saturation();
    test_abort();
    test_ignore_restart();
    test_reset_mid_settle();
    test_const_osc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_osc_freq_meter.md
RING_OSC_FREQ_METER -- requirements
Module: ring_osc_freq_meter

Interface
REQ-001 Parameter CNT_W, default 16, result counter width in bits.
REQ-002 Parameter SETTLE_CYC, default 16, clk cycles the oscillator runs before counting starts.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  design enable; low aborts any measurement.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 gate_sel  input  3  gate window select; window = 2^(gate_sel+8) clk cycles (256..32768).
REQ-008 osc_in  input  1  ring-oscillator output (divided), asynchronous to clk.
REQ-009 osc_en  output  1  ring-oscillator enable.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse when a result is published.
REQ-012 count  output  CNT_W  last published edge count.
REQ-013 sat  output  1  last published result saturated.

Function
REQ-014 FSM states: IDLE, SETTLE, MEASURE, DONE.
REQ-015 IDLE -> SETTLE when start=1 and ena=1; gate_sel latched that cycle.
REQ-016 start while busy=1 is ignored; gate_sel changes while busy are ignored.
REQ-017 osc_en is 1 in SETTLE and MEASURE only, registered, 0 otherwise.
REQ-018 SETTLE lasts exactly SETTLE_CYC cycles, then -> MEASURE; the accumulator and sat flag are cleared on entry to MEASURE.
REQ-019 osc_in passes a 2-flop synchronizer then a rising-edge detector; the edge-detector history is cleared on entry to SETTLE.
REQ-020 MEASURE lasts exactly 2^(gate_sel+8) cycles; each detected rising edge in those cycles increments the accumulator by 1.
REQ-021 Accumulator saturates at 2^CNT_W-1; any further edge sets internal sat flag, no wrap.
REQ-022 MEASURE -> DONE after the window; in DONE, count<=accumulator, sat<=sat flag, done=1 for exactly one cycle, then -> IDLE.
REQ-023 Total latency start -> done = SETTLE_CYC + window + 1 cycles.
REQ-024 count and sat hold their value until the next DONE; aborted runs never modify them.
REQ-025 ena=0 in SETTLE or MEASURE: next cycle state=IDLE, osc_en=0, done not pulsed.
REQ-026 ena=0 in DONE: publish completes normally.
REQ-027 Accuracy guaranteed only for osc_in frequency < f_clk/2; result is +/-1 edge of ideal.

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE, osc_en=0, busy=0, done=0, count=0, sat=0, accumulator, window counter, synchronizer and edge history to 0.
REQ-029 Reset deassertion mid-operation resumes from IDLE only; no measurement starts without a new start.

Structure
REQ-030 Shared package ring_osc_pkg holds the FSM state enum, gate_sel width, and the base window exponent (8).
REQ-031 Synchronizer plus edge detector is one sub-module, osc_sync_edge, with ports clk, rst_n, clr, d, rise.
REQ-032 Window length is computed from a single down-counter of width 16; no multipliers.

Verification
REQ-033 osc period 8 clk, gate_sel=0, start -> done after 16+256+1 cycles, count=32+/-1, sat=0.
REQ-034 CNT_W=8, osc period 4 clk, gate_sel=2 -> count=255, sat=1.
REQ-035 ena dropped 100 cycles into MEASURE -> osc_en=0 next cycle, no done, count keeps prior value.
REQ-036 start pulsed again during MEASURE with different gate_sel -> ignored, original window length used.
REQ-037 rst_n asserted mid-SETTLE -> all outputs 0 immediately; start after release gives normal result.
REQ-038 osc_in held constant, gate_sel=7 -> done after 16+32768+1 cycles, count=0, sat=0.
